// File: rtl/dec_scan_if.sv
// Bus bundle for dec_scan: control/address in, decoded strobe and status out.
interface dec_scan_if #(
  parameter int unsigned AW = 3
);
  logic                 en;
  logic                 mode;
  logic [AW-1:0]        a;
  logic [(1<<AW)-1:0]   d;
  logic [AW-1:0]        addr_q;
  logic                 valid;
  logic                 wrap;

  modport master (output en, mode, a, input d, addr_q, valid, wrap);
  modport slave  (input en, mode, a, output d, addr_q, valid, wrap);
endinterface

// File: rtl/dec_scan.sv
// Registered binary-to-one-hot decoder with an auto-scan mode that steps through
// every output, holding each for DWELL cycles (display/keypad strobing).
module dec_scan #(
  parameter int unsigned AW      = 3,
  parameter int unsigned DWELL   = 4,
  parameter bit          ACT_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  dec_scan_if.slave   bus
);

  localparam int unsigned N  = 1 << AW;
  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);
  localparam logic [N-1:0]  IDLE = {N{ACT_LOW}};

  logic [N-1:0]  d_r, d_n;
  logic [AW-1:0] addr_r, addr_n, addr_inc;
  logic [CW-1:0] cnt, cnt_n;
  logic          valid_r, valid_n;
  logic          wrap_r, wrap_n;
  logic          mode_q, mode_n;

  function automatic logic [N-1:0] decode(input logic [AW-1:0] x);
    logic [N-1:0] o;
    o    = '0;
    o[x] = 1'b1;
    return ACT_LOW ? ~o : o;
  endfunction

  assign addr_inc = addr_r + 1'b1;

  always_comb begin
    d_n     = d_r;
    addr_n  = addr_r;
    cnt_n   = cnt;
    valid_n = valid_r;
    wrap_n  = 1'b0;
    mode_n  = mode_q;
    if (!bus.en) begin
      // Paused: blank the strobe but keep address, dwell count and mode.
      d_n     = IDLE;
      valid_n = 1'b0;
    end else begin
      mode_n  = bus.mode;
      valid_n = 1'b1;
      if (!bus.mode || !mode_q) begin
        addr_n = bus.a;
        cnt_n  = '0;
        d_n    = decode(bus.a);
      end else if (cnt == LAST) begin
        cnt_n  = '0;
        addr_n = addr_inc;
        wrap_n = &addr_r;
        d_n    = decode(addr_inc);
      end else begin
        cnt_n  = cnt + 1'b1;
        d_n    = decode(addr_r);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_r     <= IDLE;
      addr_r  <= '0;
      cnt     <= '0;
      valid_r <= 1'b0;
      wrap_r  <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      d_r     <= d_n;
      addr_r  <= addr_n;
      cnt     <= cnt_n;
      valid_r <= valid_n;
      wrap_r  <= wrap_n;
      mode_q  <= mode_n;
    end
  end

  assign bus.d      = d_r;
  assign bus.addr_q = addr_r;
  assign bus.valid  = valid_r;
  assign bus.wrap   = wrap_r;

endmodule

// File: tb/tb_dec_scan.sv
// Directed table-driven bench for dec_scan: unit 0 is AW=3/DWELL=4/active-high,
// unit 1 is AW=3/DWELL=1/active-low.
module tb_dec_scan;

  logic clk = 1'b0;
  logic rst0, rst1;
  always #5 clk = ~clk;

  dec_scan_if #(.AW(3)) bus0 ();
  dec_scan_if #(.AW(3)) bus1 ();

  dec_scan #(.AW(3), .DWELL(4), .ACT_LOW(1'b0)) u0 (.clk(clk), .rst(rst0), .bus(bus0.slave));
  dec_scan #(.AW(3), .DWELL(1), .ACT_LOW(1'b1)) u1 (.clk(clk), .rst(rst1), .bus(bus1.slave));

  typedef struct {
    logic       u;
    logic       en;
    logic       mode;
    logic [2:0] a;
    logic [2:0] addr;
    logic       valid;
    logic       wrap;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input logic u, input logic en, input logic mode, input logic [2:0] a,
                     input logic [2:0] addr, input logic valid, input logic wrap);
    vec_t v;
    v.u = u; v.en = en; v.mode = mode; v.a = a;
    v.addr = addr; v.valid = valid; v.wrap = wrap;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_d(input logic u, input logic valid, input logic [2:0] addr);
    logic [7:0] o;
    o = valid ? (8'd1 << addr) : 8'd0;
    return u ? ~o : o;
  endfunction

  task automatic check_unit(input logic u, input string tag, input logic [2:0] addr,
                            input logic valid, input logic wrap);
    if (!u) begin
      chk({tag, ".d"},      {24'd0, bus0.d},      {24'd0, exp_d(u, valid, addr)});
      chk({tag, ".addr_q"}, {29'd0, bus0.addr_q}, {29'd0, addr});
      chk({tag, ".valid"},  {31'd0, bus0.valid},  {31'd0, valid});
      chk({tag, ".wrap"},   {31'd0, bus0.wrap},   {31'd0, wrap});
    end else begin
      chk({tag, ".d"},      {24'd0, bus1.d},      {24'd0, exp_d(u, valid, addr)});
      chk({tag, ".addr_q"}, {29'd0, bus1.addr_q}, {29'd0, addr});
      chk({tag, ".valid"},  {31'd0, bus1.valid},  {31'd0, valid});
      chk({tag, ".wrap"},   {31'd0, bus1.wrap},   {31'd0, wrap});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    bus0.en = 1'b0; bus0.mode = 1'b0; bus0.a = '0;
    bus1.en = 1'b0; bus1.mode = 1'b0; bus1.a = '0;

    // Unit 0: direct sweep
    for (int i = 0; i < 8; i++) add(0, 1, 0, 3'(i), 3'(i), 1, 0);
    // Scan from 6 through the wrap, into addr 3 with two dwell cycles spent
    add(0,1,1,6, 6,1,0); add(0,1,1,6, 6,1,0); add(0,1,1,6, 6,1,0); add(0,1,1,6, 6,1,0);
    add(0,1,1,6, 7,1,0); add(0,1,1,6, 7,1,0); add(0,1,1,6, 7,1,0); add(0,1,1,6, 7,1,0);
    add(0,1,1,6, 0,1,1); add(0,1,1,6, 0,1,0); add(0,1,1,6, 0,1,0); add(0,1,1,6, 0,1,0);
    add(0,1,1,6, 1,1,0); add(0,1,1,6, 1,1,0); add(0,1,1,6, 1,1,0); add(0,1,1,6, 1,1,0);
    add(0,1,1,6, 2,1,0); add(0,1,1,6, 2,1,0); add(0,1,1,6, 2,1,0); add(0,1,1,6, 2,1,0);
    add(0,1,1,6, 3,1,0); add(0,1,1,6, 3,1,0);
    // Pause 5 cycles, then resume: 2 more at 3, then 4
    for (int i = 0; i < 5; i++) add(0, 0, 1, 7, 3, 0, 0);
    add(0,1,1,7, 3,1,0); add(0,1,1,7, 3,1,0); add(0,1,1,7, 4,1,0);
    // Mode switch to direct, then back to scan restarting at a
    add(0,1,0,1, 1,1,0);
    add(0,1,1,5, 5,1,0); add(0,1,1,5, 5,1,0); add(0,1,1,5, 5,1,0); add(0,1,1,5, 5,1,0);
    add(0,1,1,5, 6,1,0);
    // Unit 1: active-low, dwell 1
    for (int i = 0; i < 8; i++) add(1, 1, 1, 0, 3'(i), 1, 0);
    add(1,1,1,0, 0,1,1); add(1,1,1,0, 1,1,0);
    add(1,0,1,0, 1,0,0); add(1,0,1,0, 1,0,0);
    add(1,1,1,0, 2,1,0); add(1,1,1,0, 3,1,0);
    add(1,1,0,3, 3,1,0);
    add(1,1,1,6, 6,1,0); add(1,1,1,6, 7,1,0); add(1,1,1,6, 0,1,1);

    #2;
    check_unit(0, "reset0", 3'd0, 1'b0, 1'b0);
    check_unit(1, "reset1", 3'd0, 1'b0, 1'b0);
    rst0 = 1'b0; rst1 = 1'b0;

    foreach (vecs[i]) begin
      if (!vecs[i].u) begin
        bus0.en = vecs[i].en; bus0.mode = vecs[i].mode; bus0.a = vecs[i].a;
        bus1.en = 1'b0;
      end else begin
        bus1.en = vecs[i].en; bus1.mode = vecs[i].mode; bus1.a = vecs[i].a;
        bus0.en = 1'b0;
      end
      step();
      check_unit(vecs[i].u, $sformatf("vec%0d", i), vecs[i].addr, vecs[i].valid, vecs[i].wrap);
    end

    // Reset mid-scan on unit 0: get to addr 5, then assert rst between edges
    bus1.en = 1'b0;
    bus0.en = 1'b1; bus0.mode = 1'b0; bus0.a = 3'd5;
    step();
    bus0.mode = 1'b1;
    step();
    check_unit(0, "pre_rst", 3'd5, 1'b1, 1'b0);
    #2 rst0 = 1'b1;
    #1 check_unit(0, "async_rst", 3'd0, 1'b0, 1'b0);
    step();
    check_unit(0, "rst_held", 3'd0, 1'b0, 1'b0);
    bus0.a = 3'd2; bus0.mode = 1'b1; bus0.en = 1'b1;
    rst0 = 1'b0;
    step(); check_unit(0, "rst_scan0", 3'd2, 1'b1, 1'b0);
    step(); check_unit(0, "rst_scan1", 3'd2, 1'b1, 1'b0);
    step(); check_unit(0, "rst_scan2", 3'd2, 1'b1, 1'b0);
    step(); check_unit(0, "rst_scan3", 3'd2, 1'b1, 1'b0);
    step(); check_unit(0, "rst_scan4", 3'd3, 1'b1, 1'b0);

    // Unit 1 pause gives all-ones
    bus1.en = 1'b0;
    step();
    chk("u1_pause_d", {24'd0, bus1.d}, 32'h0000_00FF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
